// File: rtl/aurora_hls_nfc_tx.sv
// Aurora native flow control request generator: XOFF/XON from the RX FIFO fill flags.
// Optional statistics counters are enabled by defining AURORA_NFC_STATS_EN.
module aurora_hls_nfc_tx #(
    parameter int unsigned RESUME_DELAY = 16,
    parameter logic [15:0] XOFF_CODE    = 16'h0100,
    parameter logic [15:0] XON_CODE     = 16'h0000
) (
    input  logic        user_clk,
    input  logic        ap_rst_n_u,
    input  logic        channel_up_u,
    input  logic        fifo_rx_prog_full_u,
    input  logic        fifo_rx_almost_full_u,
    input  logic        clear_u,
    output logic        s_axi_nfc_tvalid_u,
    input  logic        s_axi_nfc_tready_u,
    output logic [15:0] s_axi_nfc_tdata_u,
    output logic        nfc_paused_u,
    output logic        nfc_overrun_u
`ifdef AURORA_NFC_STATS_EN
    ,
    output logic [31:0] nfc_xoff_count_u,
    output logic [31:0] nfc_xon_count_u,
    output logic [31:0] nfc_pause_cycles_u
`endif
);

    localparam int unsigned            TIMER_W    = $clog2(RESUME_DELAY + 1);
    localparam logic [TIMER_W-1:0]     TIMER_LAST = TIMER_W'(RESUME_DELAY - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_SEND_XOFF,
        ST_PAUSED,
        ST_SEND_XON
    } state_t;

    state_t             state_q, state_d;
    logic               tvalid_q, tvalid_d;
    logic [15:0]        tdata_q, tdata_d;
    logic               paused_q, paused_d;
    logic               overrun_q, overrun_d;
    logic [TIMER_W-1:0] timer_q, timer_d;

    logic xoff_hs;
    logic xon_hs;

    assign xoff_hs = channel_up_u && (state_q == ST_SEND_XOFF) && s_axi_nfc_tready_u;
    assign xon_hs  = channel_up_u && (state_q == ST_SEND_XON)  && s_axi_nfc_tready_u;

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d  = state_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        paused_d = paused_q;
        timer_d  = timer_q;

        if (!channel_up_u) begin
            // Link NFC state resets with the channel, so any pending request is dropped.
            state_d  = ST_RUN;
            tvalid_d = 1'b0;
            tdata_d  = 16'h0000;
            paused_d = 1'b0;
            timer_d  = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (fifo_rx_prog_full_u) begin
                        state_d  = ST_SEND_XOFF;
                        tvalid_d = 1'b1;
                        tdata_d  = XOFF_CODE;
                    end
                end
                ST_SEND_XOFF: begin
                    if (xoff_hs) begin
                        state_d  = ST_PAUSED;
                        tvalid_d = 1'b0;
                        paused_d = 1'b1;
                        timer_d  = '0;
                    end
                end
                ST_PAUSED: begin
                    if (fifo_rx_prog_full_u) begin
                        timer_d = '0;
                    end else if (timer_q == TIMER_LAST) begin
                        state_d  = ST_SEND_XON;
                        tvalid_d = 1'b1;
                        tdata_d  = XON_CODE;
                        timer_d  = '0;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
                ST_SEND_XON: begin
                    if (xon_hs) begin
                        state_d  = ST_RUN;
                        tvalid_d = 1'b0;
                        paused_d = 1'b0;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // Set wins over a simultaneous clear.
    always_comb begin
        overrun_d = (channel_up_u && fifo_rx_almost_full_u) || (overrun_q && !clear_u);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: all flops here are control state, so every one of them takes the async reset.
    always_ff @(posedge user_clk or negedge ap_rst_n_u) begin
        if (!ap_rst_n_u) begin
            state_q   <= ST_RUN;
            tvalid_q  <= 1'b0;
            tdata_q   <= 16'h0000;
            paused_q  <= 1'b0;
            overrun_q <= 1'b0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            tvalid_q  <= tvalid_d;
            tdata_q   <= tdata_d;
            paused_q  <= paused_d;
            overrun_q <= overrun_d;
            timer_q   <= timer_d;
        end
    end

    assign s_axi_nfc_tvalid_u = tvalid_q;
    assign s_axi_nfc_tdata_u  = tdata_q;
    assign nfc_paused_u       = paused_q;
    assign nfc_overrun_u      = overrun_q;

`ifdef AURORA_NFC_STATS_EN
    logic [31:0] xoff_cnt_q, xoff_cnt_d;
    logic [31:0] xon_cnt_q, xon_cnt_d;
    logic [31:0] pause_cnt_q, pause_cnt_d;

    // Clear beats increment; the count holds at all-ones instead of wrapping.
    function automatic logic [31:0] sat_next(input logic [31:0] cnt, input logic inc, input logic clr);
        logic [31:0] nxt;
        nxt = cnt;
        if (clr) begin
            nxt = 32'd0;
        end else if (inc && (cnt != 32'hFFFF_FFFF)) begin
            nxt = cnt + 32'd1;
        end
        return nxt;
    endfunction

    always_comb begin
        xoff_cnt_d  = sat_next(xoff_cnt_q, xoff_hs, clear_u);
        xon_cnt_d   = sat_next(xon_cnt_q, xon_hs, clear_u);
        pause_cnt_d = sat_next(pause_cnt_q, paused_q, clear_u);
    end

    always_ff @(posedge user_clk or negedge ap_rst_n_u) begin
        if (!ap_rst_n_u) begin
            xoff_cnt_q  <= 32'd0;
            xon_cnt_q   <= 32'd0;
            pause_cnt_q <= 32'd0;
        end else begin
            xoff_cnt_q  <= xoff_cnt_d;
            xon_cnt_q   <= xon_cnt_d;
            pause_cnt_q <= pause_cnt_d;
        end
    end

    assign nfc_xoff_count_u   = xoff_cnt_q;
    assign nfc_xon_count_u    = xon_cnt_q;
    assign nfc_pause_cycles_u = pause_cnt_q;
`endif

endmodule

// File: tb/tb_aurora_hls_nfc_tx.sv
// Self-checking bench for aurora_hls_nfc_tx: request-level model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_aurora_hls_nfc_tx;

    localparam int          R    = 16;
    localparam logic [15:0] XOFF = 16'h0100;
    localparam logic [15:0] XON  = 16'h0000;

    logic        user_clk = 1'b0;
    logic        ap_rst_n_u = 1'b0;
    logic        channel_up_u = 1'b0;
    logic        pf = 1'b0;
    logic        af = 1'b0;
    logic        clear_u = 1'b0;
    logic        tready = 1'b0;
    logic        tvalid;
    logic [15:0] tdata;
    logic        paused;
    logic        overrun;
`ifdef AURORA_NFC_STATS_EN
    logic [31:0] xoff_cnt, xon_cnt, pause_cnt;
`endif

    aurora_hls_nfc_tx #(
        .RESUME_DELAY(R),
        .XOFF_CODE   (XOFF),
        .XON_CODE    (XON)
    ) dut (
        .user_clk             (user_clk),
        .ap_rst_n_u           (ap_rst_n_u),
        .channel_up_u         (channel_up_u),
        .fifo_rx_prog_full_u  (pf),
        .fifo_rx_almost_full_u(af),
        .clear_u              (clear_u),
        .s_axi_nfc_tvalid_u   (tvalid),
        .s_axi_nfc_tready_u   (tready),
        .s_axi_nfc_tdata_u    (tdata),
        .nfc_paused_u         (paused),
        .nfc_overrun_u        (overrun)
`ifdef AURORA_NFC_STATS_EN
        ,
        .nfc_xoff_count_u     (xoff_cnt),
        .nfc_xon_count_u      (xon_cnt),
        .nfc_pause_cycles_u   (pause_cnt)
`endif
    );

    always #5 user_clk = ~user_clk;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, wanted %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    // Request-level model: one outstanding request, a paused flag, and a run of low cycles.
    bit          m_out;
    logic [15:0] m_code;
    bit          m_paused;
    bit          m_ovr;
    int          m_low;
    int          m_xoff_n, m_xon_n, m_pause_n;

    always @(posedge user_clk or negedge ap_rst_n_u) begin : model
        bit hs_off, hs_on;
        if (!ap_rst_n_u) begin
            m_out = 0; m_code = 16'h0000; m_paused = 0; m_ovr = 0; m_low = 0;
            m_xoff_n = 0; m_xon_n = 0; m_pause_n = 0;
        end else begin
            hs_off = 0;
            hs_on  = 0;
            if (clear_u) m_pause_n = 0;
            else if (m_paused) m_pause_n++;
            m_ovr = (channel_up_u && af) || (m_ovr && !clear_u);
            if (!channel_up_u) begin
                m_out = 0; m_code = 16'h0000; m_paused = 0; m_low = 0;
            end else if (m_out) begin
                if (tready) begin
                    m_out = 0;
                    if (m_code == XOFF) begin
                        m_paused = 1; m_low = 0; hs_off = 1;
                    end else begin
                        m_paused = 0; hs_on = 1;
                    end
                end
            end else if (!m_paused) begin
                if (pf) begin
                    m_out = 1; m_code = XOFF;
                end
            end else begin
                if (pf) m_low = 0;
                else m_low++;
                if (m_low == R) begin
                    m_out = 1; m_code = XON; m_low = 0;
                end
            end
            if (clear_u) begin
                m_xoff_n = 0; m_xon_n = 0;
            end else begin
                if (hs_off) m_xoff_n++;
                if (hs_on)  m_xon_n++;
            end
        end
    end

    always @(negedge user_clk) begin
        if (cmp_en) begin
            check("cyc_tvalid", 32'(tvalid), 32'(m_out));
            check("cyc_tdata", 32'(tdata), 32'(m_code));
            check("cyc_paused", 32'(paused), 32'(m_paused));
            check("cyc_overrun", 32'(overrun), 32'(m_ovr));
`ifdef AURORA_NFC_STATS_EN
            check("cyc_xoff_cnt", xoff_cnt, 32'(m_xoff_n));
            check("cyc_xon_cnt", xon_cnt, 32'(m_xon_n));
            check("cyc_pause_cnt", pause_cnt, 32'(m_pause_n));
`endif
        end
    end

    initial begin
        repeat (3) tick();
        ap_rst_n_u = 1'b1;
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_tdata", 32'(tdata), 32'h0000);
        check("rst_paused", 32'(paused), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        cmp_en = 1'b1;

        // XOFF latency: one cycle from prog_full to tvalid, paused the cycle after
        channel_up_u = 1'b1;
        tready = 1'b1;
        repeat (9) tick();
        pf = 1'b1;
        tick();
        check("xoff_valid", 32'(tvalid), 32'd1);
        check("xoff_data", 32'(tdata), 32'h0100);
        tick();
        check("xoff_done_valid", 32'(tvalid), 32'd0);
        check("xoff_done_paused", 32'(paused), 32'd1);
        repeat (4) tick();

        // Resume delay: XON exactly R cycles after prog_full falls
        pf = 1'b0;
        for (int i = 1; i <= R; i++) begin
            tick();
            check("xon_wait", 32'(tvalid), 32'(i == R));
        end
        check("xon_data", 32'(tdata), 32'h0000);
        tick();
        check("xon_done_valid", 32'(tvalid), 32'd0);
        check("xon_done_paused", 32'(paused), 32'd0);

        // Glitch at low-cycle 8 restarts the count
        pf = 1'b1;
        tick();
        tick();
        pf = 1'b0;
        repeat (7) tick();
        pf = 1'b1;
        tick();
        pf = 1'b0;
        for (int i = 1; i <= R; i++) begin
            tick();
            check("glitch_wait", 32'(tvalid), 32'(i == R));
        end
        tick();

        // Stall in SEND_XOFF
        tready = 1'b0;
        pf = 1'b1;
        tick();
        check("stall_start", 32'(tvalid), 32'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("stall_valid", 32'(tvalid), 32'd1);
            check("stall_data", 32'(tdata), 32'h0100);
            check("stall_paused", 32'(paused), 32'd0);
        end
        tready = 1'b1;
        tick();
        check("stall_end_valid", 32'(tvalid), 32'd0);
        check("stall_end_paused", 32'(paused), 32'd1);

        // Re-trigger during a stalled XON
        tready = 1'b0;
        pf = 1'b0;
        repeat (R) tick();
        check("retrig_xon_valid", 32'(tvalid), 32'd1);
        check("retrig_xon_data", 32'(tdata), 32'h0000);
        pf = 1'b1;
        repeat (5) tick();
        check("retrig_hold", 32'(tvalid), 32'd1);
        tready = 1'b1;
        tick();
        check("retrig_run_valid", 32'(tvalid), 32'd0);
        check("retrig_run_paused", 32'(paused), 32'd0);
        tick();
        check("retrig_xoff_valid", 32'(tvalid), 32'd1);
        check("retrig_xoff_data", 32'(tdata), 32'h0100);
        tick();
        check("retrig_paused", 32'(paused), 32'd1);

        // Channel down mid SEND_XOFF
        channel_up_u = 1'b0;
        tick();
        check("down_paused", 32'(paused), 32'd0);
        channel_up_u = 1'b1;
        tready = 1'b0;
        tick();
        check("down_xoff", 32'(tvalid), 32'd1);
        tick();
        channel_up_u = 1'b0;
        tick();
        check("down_valid", 32'(tvalid), 32'd0);
        check("down_data", 32'(tdata), 32'h0000);
        check("down_paused2", 32'(paused), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("down_quiet", 32'(tvalid), 32'd0);
        end
        channel_up_u = 1'b1;
        tick();
        check("up_xoff_valid", 32'(tvalid), 32'd1);
        check("up_xoff_data", 32'(tdata), 32'h0100);
        tready = 1'b1;
        tick();
        check("up_paused", 32'(paused), 32'd1);

        // Overrun: set wins over clear
        af = 1'b1;
        clear_u = 1'b1;
        tick();
        check("ovr_set", 32'(overrun), 32'd1);
        af = 1'b0;
        clear_u = 1'b0;
        tick();
        check("ovr_sticky", 32'(overrun), 32'd1);
        clear_u = 1'b1;
        tick();
        check("ovr_clear", 32'(overrun), 32'd0);
        clear_u = 1'b0;
        channel_up_u = 1'b0;
        af = 1'b1;
        tick();
        check("ovr_chan_down", 32'(overrun), 32'd0);
        af = 1'b0;
        pf = 1'b0;

`ifdef AURORA_NFC_STATS_EN
        // Three XOFF/XON rounds, paused spans of k+17 cycles each
        channel_up_u = 1'b1;
        tready = 1'b1;
        clear_u = 1'b1;
        tick();
        clear_u = 1'b0;
        for (int r = 0; r < 3; r++) begin
            pf = 1'b1;
            tick();
            tick();
            repeat (3 + 2 * r) tick();
            pf = 1'b0;
            repeat (R) tick();
            tick();
        end
        check("stat_xoff", xoff_cnt, 32'd3);
        check("stat_xon", xon_cnt, 32'd3);
        check("stat_pause", pause_cnt, 32'd66);
        clear_u = 1'b1;
        tick();
        clear_u = 1'b0;
        check("stat_clear", pause_cnt, 32'd0);
`endif

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
